// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO read port among N_REQ consumers.
// Grants one consumer for up to BURST_LEN beats, with one IDLE bubble between grants.
module fifo_rd_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_REQ-1:0]      REQ,
  input  logic [N_REQ-1:0]      RDY,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  R_INC,
  output logic [N_REQ-1:0]      GNT,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic [N_REQ-1:0]      DVALID,
  output logic                  BUSY
);

  localparam int                IDX_W    = $clog2(N_REQ);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]    N_WIDE   = (IDX_W + 1)'(N_REQ);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;
  logic             beat;
  logic [N_REQ-1:0] dvalid_c;

  // Search last+1, last+2, ... (mod N_REQ); the previous winner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_q} + (IDX_W + 1)'(k);
      if (cand >= N_WIDE) cand = cand - N_WIDE;
      if (!win_found && REQ[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gidx_d   = gidx_q;
    beat     = 1'b0;
    dvalid_c = '0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d        = S_BURST;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          cnt_d          = '0;
          gidx_d         = win_idx;
        end
      end
      S_BURST: begin
        beat             = REQ[gidx_q] & RDY[gidx_q] & ~EMPTY;
        dvalid_c[gidx_q] = REQ[gidx_q] & ~EMPTY;
        // Dropping REQ releases the grant without a beat; EMPTY/RDY stalls just hold.
        if (!REQ[gidx_q] || (beat && (cnt_q == CNT_LAST))) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          last_d  = gidx_q;
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking updates so every register sees the same pre-edge values.
    if (RST) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
    end
  end

  // Reset masks the combinational outputs so an aborted burst never pops the FIFO.
  assign R_INC  = beat & ~RST;
  assign DVALID = RST ? '0 : dvalid_c;
  assign BUSY   = (state_q == S_BURST) & ~RST;
  assign GNT    = gnt_q;
  assign DOUT   = RD_DATA;

  a_gnt_onehot0 : assert property (@(posedge CLK) disable iff (RST) $onehot0(GNT));
  a_rinc_safe   : assert property (@(posedge CLK) R_INC |-> (!EMPTY && (GNT != '0)));
  a_cnt_bound   : assert property (@(posedge CLK) disable iff (RST) cnt_q <= CNT_LAST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: directed stimulus, expected beats queued
// by the stimulus thread and compared by an independent negedge monitor.
module tb_fifo_rd_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] RDY;
  logic       EMPTY;
  logic [7:0] RD_DATA;
  logic       R_INC;
  logic [3:0] GNT;
  logic [7:0] DOUT;
  logic [3:0] DVALID;
  logic       BUSY;

  fifo_rd_arbiter #(
    .N_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .RDY(RDY), .EMPTY(EMPTY), .RD_DATA(RD_DATA),
    .R_INC(R_INC), .GNT(GNT), .DOUT(DOUT), .DVALID(DVALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // FIFO read-side model: stimulus owns writes, the pop process owns the read pointer.
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       flush = 1'b0;
  logic       pop_pending;
  assign EMPTY   = (wr_ptr == rd_ptr);
  assign RD_DATA = mem[rd_ptr];

  typedef struct {
    int         idx;
    logic [7:0] data;
  } beat_t;
  beat_t exp_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int cyc_cnt = 0;
  int last_beat_cyc = 0;
  int start_cyc;

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = 8'(first + i);
      wr_ptr      = wr_ptr + 8'd1;
    end
  endtask

  task automatic exp_burst(input int idx, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.idx  = idx;
      b.data = 8'(first + i);
      exp_q.push_back(b);
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic release_all();
    REQ = 4'b0000;
    for (int i = 0; i < 10 && BUSY; i++) step();
    check("idle_return", {31'b0, BUSY}, 0);
  endtask

  task automatic do_reset();
    flush = 1'b1;
    RST   = 1'b1;
    REQ   = 4'b0000;
    RDY   = 4'b0000;
    step();
    step();
    flush = 1'b0;
    RST   = 1'b0;
  endtask

  // Pop happens at +2 so it never races stimulus driven at +1.
  initial forever begin
    @(negedge CLK);
    pop_pending = R_INC;
    @(posedge CLK);
    #2;
    if (flush) rd_ptr = wr_ptr;
    else if (pop_pending) rd_ptr = rd_ptr + 8'd1;
  end

  // Monitor: per-cycle invariants, and every R_INC beat against the scoreboard.
  initial forever begin
    beat_t      e;
    logic [3:0] oh;
    logic [2:0] viol;
    @(negedge CLK);
    viol[0] = !$onehot0(GNT);
    viol[1] = R_INC && (EMPTY || (GNT == 4'b0000));
    viol[2] = |(DVALID & ~GNT);
    check("invariants", {29'b0, viol}, 0);
    if (R_INC) begin
      last_beat_cyc = cyc_cnt;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {31'b0, R_INC}, 0);
      end else begin
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.idx;
        check("beat", {16'b0, DVALID, GNT, DOUT}, {16'b0, oh, oh, e.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    REQ = 4'b0000;
    RDY = 4'b0000;

    // Reset and first grant: requester 0 wins, 4 beats, bubble, then requester 1.
    step();
    @(negedge CLK);
    check("rst_outputs", {22'b0, GNT, DVALID, BUSY, R_INC}, 0);
    step();
    RST = 1'b0;
    push_words('h10, 8);
    exp_burst(0, 'h10, 4);
    exp_burst(1, 'h14, 4);
    REQ = 4'b1111;
    RDY = 4'b1111;
    @(negedge CLK);
    check("t1_pre_gnt", {28'b0, GNT}, 0);
    step();
    @(negedge CLK);
    check("t1_first_gnt", {27'b0, BUSY, GNT}, {27'b0, 1'b1, 4'b0001});
    repeat (4) step();
    @(negedge CLK);
    check("t1_bubble", {27'b0, BUSY, GNT}, 0);
    step();
    @(negedge CLK);
    check("t1_second_gnt", {28'b0, GNT}, {28'b0, 4'b0010});
    drain("t1", 40);
    release_all();

    // Full rotation: 8 bursts 0,1,2,3,0,1,2,3 at 5 cycles per grant.
    do_reset();
    push_words('h20, 32);
    for (int b = 0; b < 8; b++) exp_burst(b % 4, 'h20 + 4 * b, 4);
    REQ = 4'b1111;
    RDY = 4'b1111;
    start_cyc = cyc_cnt;
    drain("t2", 100);
    check("t2_cycles", last_beat_cyc - start_cyc, 39);
    release_all();

    // Empty stall: 2 beats, grant held while empty, 2 more beats, then release.
    do_reset();
    push_words('h40, 2);
    exp_burst(2, 'h40, 2);
    REQ = 4'b0100;
    RDY = 4'b1111;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("t3_stall_hold", {22'b0, BUSY, GNT, DVALID, R_INC},
            {22'b0, 1'b1, 4'b0100, 4'b0000, 1'b0});
      step();
    end
    push_words('h42, 2);
    exp_burst(2, 'h42, 2);
    step();
    step();
    REQ = 4'b0000;
    @(negedge CLK);
    check("t3_release", {27'b0, BUSY, GNT}, 0);
    drain("t3", 5);
    release_all();

    // RDY backpressure and early release; requester 1 becomes lowest priority.
    do_reset();
    push_words('h50, 8);
    exp_burst(1, 'h50, 2);
    exp_burst(2, 'h52, 4);
    REQ = 4'b0110;
    RDY = 4'b1111;
    step();
    @(negedge CLK);
    check("t4_gnt", {28'b0, GNT}, {28'b0, 4'b0010});
    step();
    RDY = 4'b1101;
    @(negedge CLK);
    check("t4_rdy_stall", {23'b0, R_INC, DVALID, GNT}, {23'b0, 1'b0, 4'b0010, 4'b0010});
    step();
    RDY = 4'b1111;
    step();
    REQ = 4'b0101;
    @(negedge CLK);
    check("t4_early_rel", {26'b0, R_INC, BUSY, GNT}, {26'b0, 1'b0, 1'b1, 4'b0010});
    step();
    @(negedge CLK);
    check("t4_bubble", {27'b0, BUSY, GNT}, 0);
    step();
    @(negedge CLK);
    check("t4_next_gnt", {28'b0, GNT}, {28'b0, 4'b0100});
    drain("t4", 20);
    release_all();

    // Single requester: 12 words in 3 bursts with one-cycle bubbles.
    do_reset();
    push_words('h60, 12);
    exp_burst(2, 'h60, 12);
    REQ = 4'b0100;
    RDY = 4'b1111;
    start_cyc = cyc_cnt;
    repeat (5) step();
    @(negedge CLK);
    check("t5_bubble", {27'b0, BUSY, GNT}, 0);
    drain("t5", 30);
    check("t5_cycles", last_beat_cyc - start_cyc, 14);
    release_all();

    // Reset after beat 1 of a burst to 3, then a fresh full burst to 3.
    do_reset();
    push_words('h70, 8);
    exp_burst(3, 'h70, 1);
    exp_burst(3, 'h71, 4);
    REQ = 4'b1000;
    RDY = 4'b1111;
    step();
    @(negedge CLK);
    check("t6_gnt", {28'b0, GNT}, {28'b0, 4'b1000});
    step();
    RST = 1'b1;
    @(negedge CLK);
    check("t6_rst_cycle", {26'b0, R_INC, BUSY, DVALID}, 0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("t6_after_rst", {27'b0, BUSY, GNT}, 0);
    step();
    @(negedge CLK);
    check("t6_regrant", {28'b0, GNT}, {28'b0, 4'b1000});
    repeat (4) step();
    REQ = 4'b0000;
    @(negedge CLK);
    check("t6_burst_end", {27'b0, BUSY, GNT}, 0);
    drain("t6", 5);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
Round-robin burst arbiter that shares the single read port of the asynchronous FIFO among N_REQ consumers in the read clock domain. It grants one consumer at a time and drives the FIFO read-increment for up to BURST_LEN beats. It steers the FIFO EMPTY/data to the granted consumer, then rotates priority. It sits between the FIFO read side and the consumers, clocked by the FIFO read clock.

Parameters:
N_REQ, 4, number of consumers (2..8)
DATA_WIDTH, 8, FIFO data word width
BURST_LEN, 4, max beats per grant (1..255)
CNT_W, 8, beat counter width; must hold BURST_LEN

Ports:
CLK  input  1  read-domain clock, same clock as the FIFO read side
RST  input  1  reset; synchronous, active-high
REQ  input  N_REQ  per-consumer read request, level
RDY  input  N_REQ  per-consumer ready to accept a beat
EMPTY  input  1  FIFO empty flag (registered in FIFO)
RD_DATA  input  DATA_WIDTH  FIFO read data at current read address
R_INC  output  1  FIFO read increment
GNT  output  N_REQ  one-hot grant, registered
DOUT  output  DATA_WIDTH  RD_DATA passthrough
DVALID  output  N_REQ  per-consumer beat valid
BUSY  output  1  high while in BURST state

Behaviour:
- States: IDLE, BURST. Registered: state, GNT, beat count cnt, last-granted index last.
- Reset (RST high at a CLK edge): state=IDLE, GNT=0, cnt=0, last=N_REQ-1 (so requester 0 wins first). R_INC=0, DVALID=0, BUSY=0 during and after reset. Reset mid-burst aborts the burst immediately. No R_INC is issued in the reset cycle.
- IDLE: R_INC=0, DVALID=0. If REQ!=0, pick the first set bit searching last+1, last+2, ... modulo N_REQ. Next cycle: GNT=onehot(winner), cnt=0, state=BURST. If REQ==0, stay in IDLE.
- Grant latency: REQ seen high at edge t. GNT high after edge t, so the first R_INC is possible in the cycle following edge t.
- BURST, granted index g:
  - R_INC = REQ[g] & RDY[g] & ~EMPTY (combinational).
  - DVALID[g] = REQ[g] & ~EMPTY. Other DVALID bits are 0.
  - DOUT = RD_DATA always.
  - A beat transfers on an edge where R_INC=1, and cnt increments.
- Burst exit, evaluated at each edge in BURST:
  - (a) Beat transfers and cnt==BURST_LEN-1: last beat.
  - (b) REQ[g]==0: early release; no beat that cycle.
  - On exit: state=IDLE, GNT=0, cnt=0, last=g.
  - Exactly one IDLE bubble cycle is always inserted between bursts, even if other REQ bits are high.
- EMPTY in BURST: the grant is held and cnt is frozen; no timeout. The consumer may drop REQ to release.
- RDY low: stall, same as EMPTY; the grant is held.
- Round-robin: after granting g, g has lowest priority in the next arbitration. The sole requester may be re-granted after the bubble.
- Invariants:
  - GNT is zero or one-hot.
  - R_INC never asserts when EMPTY=1 or GNT=0.
  - Beats per grant never exceed BURST_LEN.
- REQ changes on non-granted lines during BURST are ignored until the next IDLE.

Test Plan:
- Reset/first grant: RST high 2 cycles, then REQ=4'b1111, FIFO holding 8 words -> GNT=0001 one cycle after; 4 R_INC pulses on DVALID[0]; GNT=0 for 1 cycle; then GNT=0010.
- Full rotation: REQ=1111 constantly, FIFO with 32 words -> grant order 0,1,2,3,0...; 4 beats each; total 20 cycles per 16 words. BURST_LEN=4 gives 5 cycles per grant.
- Empty stall: grant to 2, FIFO has 2 words -> 2 beats; BUSY holds with cnt=2; write 2 more words -> 2 more beats, then release. Never R_INC while EMPTY=1.
- Early release and RDY backpressure: grant to 1, RDY[1] toggles 1,0,1 -> beats only on RDY=1 cycles. Drop REQ[1] after beat 2 -> IDLE next cycle, last=1, next grant to 2 if REQ[2]=1.
- Single requester: REQ=0100 only -> repeated grants to 2 with 1-cycle bubbles; 12 words read in 3 bursts.
- Reset mid-burst: RST high after beat 1 of a burst to 3 -> R_INC=0 and GNT=0 from that edge; after reset with REQ=1000 -> grant restarts at 3, cnt=0, and a full 4-beat burst follows.
